// File: rtl/divider.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock.
// Returns {remainder, quotient} on dataOut and paces the caller with start/busy/done.
module divider #(
  parameter int         WIDTH = 32,
  parameter logic [2:0] DIVU  = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           signal,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic             accept;

  assign accept = start && (signal == DIVU) && (state != RUN);
  assign busy   = (state == RUN);

  // One restoring step: the dividend bits stream out of quoReg into the remainder,
  // and the borrow of the widened subtract decides the new quotient bit.
  always_comb begin
    remShift = {remReg, quoReg[WIDTH-1]};
    trial    = remShift - {1'b0, divisor};
    remNext  = remShift[WIDTH-1:0];
    quoNext  = {quoReg[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      remNext = trial[WIDTH-1:0];
      quoNext = {quoReg[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      remReg  <= '0;
      quoReg  <= '0;
      divisor <= '0;
      count   <= '0;
      done    <= 1'b0;
      dataOut <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          remReg <= remNext;
          quoReg <= quoNext;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            dataOut <= {remNext, quoNext};
          end
        end
        default: begin
          // IDLE and DONE both accept a new op; DONE otherwise falls back to IDLE.
          if (accept) begin
            divisor <= dataB;
            if (dataB == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              dataOut <= {dataA, {WIDTH{1'b1}}};
            end else begin
              state  <= RUN;
              remReg <= '0;
              quoReg <= dataA;
              count  <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
